ram_init_streamer: RTL and testbench

Parametrised successor to the dummy-data RAM loader. It fills a multi-port RAM with NUM_PORTS words per cycle. Data comes from a valid/ready input stream or from an internal pattern generator (constant fill or address-ramp). It sits between testbench/host data sources and the AES key/state RAMs, and runs a start/busy/finished handshake so downstream cipher logic knows when memory contents are valid.

---
 rtl/ram_init_pkg.sv | 22 ++
 rtl/ram_init_gather.sv | 61 ++++++
 rtl/ram_init_streamer.sv | 195 +++++++++++++++++++
 tb/tb_ram_init_streamer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_init_pkg.sv
// Shared encodings and lane helpers for the RAM init streamer and its gather packer.
package ram_init_pkg;

    localparam logic [1:0] MODE_STREAM = 2'd0;
    localparam logic [1:0] MODE_FILL   = 2'd1;
    localparam logic [1:0] MODE_RAMP   = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit offset of a lane inside a packed port vector, port 0 in the LSBs.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // The reserved mode encoding behaves as constant fill.
    function automatic logic [1:0] normalize_mode(input logic [1:0] m);
        return (m == MODE_STREAM || m == MODE_RAMP) ? m : MODE_FILL;
    endfunction

endpackage

// File: rtl/ram_init_gather.sv
// Packs accepted stream words into NUM_PORTS-wide write beats; emit is raised on the
// accepting cycle so the parent can register the beat for the following cycle.
module ram_init_gather
    import ram_init_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [DATA_WIDTH-1:0]           push_data,
    input  logic                            last,
    output logic                            emit,
    output logic [NUM_PORTS-1:0]            beat_en,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] beat_data
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_PORTS*DATA_WIDTH-1:0] lanes_q, lanes_d;

    always_comb begin
        idx_d     = idx_q;
        lanes_d   = lanes_q;
        emit      = 1'b0;
        beat_en   = '0;
        beat_data = '0;
        if (push) begin
            emit  = last || (idx_q == IDX_W'(NUM_PORTS - 1));
            idx_d = emit ? '0 : idx_q + IDX_W'(1);
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    lanes_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = push_data;
                end
            end
        end
        // Lanes above idx hold stale words from an earlier beat, so they are masked out.
        if (emit) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (IDX_W'(i) <= idx_q) begin
                    beat_en[i] = 1'b1;
                    beat_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
                        lanes_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/ram_init_streamer.sv
// Fills a multi-port RAM NUM_PORTS words per cycle from a stream or a fill/ramp pattern,
// with a start/busy/finished handshake telling downstream logic when memory is valid.
module ram_init_streamer
    import ram_init_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 2,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [CNT_WIDTH-1:0]            word_count,
    input  logic [DATA_WIDTH-1:0]           fill_value,
    input  logic                            s_valid,
    input  logic [DATA_WIDTH-1:0]           s_data,
    output logic                            s_ready,
    output logic [NUM_PORTS-1:0]            wr_en,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic                            busy,
    output logic                            finished
);

    logic [1:0]                      state_q, state_d;
    logic [1:0]                      mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]           ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]           pattern_q, pattern_d;
    logic [CNT_WIDTH-1:0]            remaining_q, remaining_d;
    logic [NUM_PORTS-1:0]            wr_en_q, wr_en_d;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_PORTS*DATA_WIDTH-1:0] data_q, data_d;
    logic                            s_ready_q, s_ready_d;
    logic                            busy_q, busy_d;
    logic                            finished_q, finished_d;

    logic [1:0]                      cur_mode;
    logic [ADDR_WIDTH-1:0]           cur_ptr;
    logic [DATA_WIDTH-1:0]           cur_pattern;
    logic [CNT_WIDTH-1:0]            cur_rem;
    logic [CNT_WIDTH-1:0]            beat_len;
    logic [CNT_WIDTH-1:0]            stream_len;
    logic                            do_pattern;
    logic                            push;
    logic                            last_word;
    logic                            emit;
    logic [NUM_PORTS-1:0]            beat_en;
    logic [NUM_PORTS*DATA_WIDTH-1:0] beat_data;

    // In IDLE the first pattern beat is built straight from the start inputs so writes
    // land the cycle after start; from then on the latched copies take over.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_mode    = normalize_mode(mode);
            cur_ptr     = base_addr;
            cur_pattern = fill_value;
            cur_rem     = word_count;
        end else begin
            cur_mode    = mode_q;
            cur_ptr     = ptr_q;
            cur_pattern = pattern_q;
            cur_rem     = remaining_q;
        end
    end

    assign do_pattern = (cur_mode != MODE_STREAM) && (cur_rem != '0) &&
                        ((state_q == ST_IDLE && start) || state_q == ST_LOAD);
    assign beat_len   = (cur_rem < CNT_WIDTH'(NUM_PORTS)) ? cur_rem : CNT_WIDTH'(NUM_PORTS);
    assign push       = s_valid && s_ready_q;
    assign last_word  = (remaining_q == CNT_WIDTH'(1));

    ram_init_gather #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_PORTS (NUM_PORTS)
    ) u_gather (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(s_data),
        .last     (last_word),
        .emit     (emit),
        .beat_en  (beat_en),
        .beat_data(beat_data)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ptr_d       = ptr_q;
        pattern_d   = pattern_q;
        remaining_d = remaining_q;
        wr_en_d     = '0;
        addr_d      = '0;
        data_d      = '0;
        s_ready_d   = 1'b0;
        busy_d      = busy_q;
        finished_d  = finished_q;
        stream_len  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = cur_mode;
                    ptr_d       = cur_ptr;
                    pattern_d   = cur_pattern;
                    remaining_d = cur_rem;
                    busy_d      = 1'b1;
                    finished_d  = 1'b0;
                    state_d     = (cur_rem == '0) ? ST_DONE : ST_LOAD;
                    s_ready_d   = (cur_mode == MODE_STREAM) && (cur_rem != '0);
                end
            end
            ST_LOAD: begin
                if (cur_mode == MODE_STREAM) begin
                    if (push) begin
                        remaining_d = remaining_q - CNT_WIDTH'(1);
                    end
                    s_ready_d = (remaining_d != '0);
                    if (emit) begin
                        wr_en_d = beat_en;
                        data_d  = beat_data;
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            addr_d[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] = ptr_q + ADDR_WIDTH'(i);
                            if (beat_en[i]) begin
                                stream_len = stream_len + CNT_WIDTH'(1);
                            end
                        end
                        ptr_d = ptr_q + ADDR_WIDTH'(stream_len);
                    end
                    if (push && last_word) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d     = 1'b0;
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_pattern) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_en_d[i] = (CNT_WIDTH'(i) < beat_len);
                addr_d[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] = cur_ptr + ADDR_WIDTH'(i);
                data_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
                    (cur_mode == MODE_RAMP) ? cur_pattern + DATA_WIDTH'(i) : cur_pattern;
            end
            ptr_d = cur_ptr + ADDR_WIDTH'(beat_len);
            if (cur_mode == MODE_RAMP) begin
                pattern_d = cur_pattern + DATA_WIDTH'(beat_len);
            end
            remaining_d = cur_rem - beat_len;
            state_d     = (remaining_d == '0) ? ST_DONE : ST_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_STREAM;
            ptr_q       <= '0;
            pattern_q   <= '0;
            remaining_q <= '0;
            wr_en_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ptr_q       <= ptr_d;
            pattern_q   <= pattern_d;
            remaining_q <= remaining_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign wr_en    = wr_en_q;
    assign addr     = addr_q;
    assign data_out = data_q;
    assign busy     = busy_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_ram_init_streamer.sv
// Scoreboard bench for ram_init_streamer: expected write beats are queued as stimulus is
// driven and popped whenever the DUT raises wr_en.
module tb_ram_init_streamer;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NP = 2;
    localparam int CW = AW + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [1:0]           mode = '0;
    logic [AW-1:0]        base_addr = '0;
    logic [CW-1:0]        word_count = '0;
    logic [DW-1:0]        fill_value = '0;
    logic                 s_valid = 1'b0;
    logic [DW-1:0]        s_data = '0;
    logic                 s_ready;
    logic [NP-1:0]        wr_en;
    logic [NP*AW-1:0]     addr;
    logic [NP*DW-1:0]     data_out;
    logic                 busy;
    logic                 finished;

    typedef struct {
        logic [NP-1:0]    en;
        logic [NP*AW-1:0] addr;
        logic [NP*DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    ram_init_streamer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_PORTS (NP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .word_count(word_count),
        .fill_value(fill_value),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .addr      (addr),
        .data_out  (data_out),
        .busy      (busy),
        .finished  (finished)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wr_en != '0) begin
            beat_t e;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_wr_en", 64'(wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_en", 64'(wr_en), 64'(e.en));
                for (int i = 0; i < NP; i++) begin
                    if (e.en[i]) begin
                        checkOutput($sformatf("addr%0d", i), 64'(addr[i*AW +: AW]), 64'(e.addr[i*AW +: AW]));
                        checkOutput($sformatf("data%0d", i), 64'(data_out[i*DW +: DW]), 64'(e.data[i*DW +: DW]));
                    end
                end
            end
        end
    end

    // Reference beats for fill/ramp loads, derived from the configuration alone.
    task automatic pushPatternBeats(input logic [1:0] m, input logic [AW-1:0] b, input int cnt, input logic [DW-1:0] f);
        beat_t e;
        for (int off = 0; off < cnt; off += NP) begin
            e.en   = '0;
            e.addr = '0;
            e.data = '0;
            for (int i = 0; i < NP; i++) begin
                e.en[i] = (off + i < cnt);
                e.addr[i*AW +: AW] = b + AW'(off + i);
                e.data[i*DW +: DW] = (m == 2'd2) ? f + DW'(off + i) : f;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [AW-1:0] b, input logic [CW-1:0] cnt,
                                 input logic [DW-1:0] f, input logic [15:0] vpat, input int vlen,
                                 input int pulse_cyc);
        int            accepted = 0;
        int            lanes = 0;
        int            last_wr = 0;
        int            busy_cnt = 0;
        int            fin_cyc = 0;
        int            last_acc = 0;
        int            nb;
        logic [AW-1:0] wptr = b;
        bit            stream = (m == 2'd0);
        beat_t         gb;
        gb.en   = '0;
        gb.addr = '0;
        gb.data = '0;
        if (!stream) pushPatternBeats(m, b, int'(cnt), f);
        @(posedge clk); #1;
        start = 1'b1; mode = m; base_addr = b; word_count = cnt; fill_value = f; s_valid = 1'b0;
        for (int c = 1; c <= 300 && fin_cyc == 0; c++) begin
            bit            v;
            logic          exp_ready;
            logic [DW-1:0] d;
            @(posedge clk); #1;
            start = (c == pulse_cyc);
            if (c == pulse_cyc) begin
                mode = 2'd2; base_addr = 4'd7; word_count = 5'd3; fill_value = 8'h33;
            end
            v = stream && ((c <= vlen) ? vpat[c-1] : 1'b1);
            d = f + DW'(accepted);
            s_valid = v;
            s_data  = v ? d : 8'hEE;
            @(negedge clk);
            if (c == 1) begin
                checkOutput("busy_after_start", 64'(busy), 64'd1);
                checkOutput("finished_cleared", 64'(finished), 64'd0);
            end
            if (stream) begin
                exp_ready = (accepted < int'(cnt));
                checkOutput("s_ready", 64'(s_ready), 64'(exp_ready));
                if (v && exp_ready) begin
                    gb.en[lanes] = 1'b1;
                    gb.data[lanes*DW +: DW] = d;
                    lanes++;
                    accepted++;
                    last_acc = c;
                    if (lanes == NP || accepted == int'(cnt)) begin
                        for (int i = 0; i < NP; i++) gb.addr[i*AW +: AW] = wptr + AW'(i);
                        exp_q.push_back(gb);
                        wptr = wptr + AW'(lanes);
                        lanes = 0;
                        gb.en = '0;
                        gb.data = '0;
                    end
                end
            end
            if (wr_en != '0) last_wr = c;
            if (busy) busy_cnt++;
            if (finished) fin_cyc = c;
        end
        s_valid = 1'b0;
        if (fin_cyc == 0) begin
            checkOutput("finish_timeout", 64'd0, 64'd1);
        end else begin
            if (cnt == '0) begin
                checkOutput("last_wr_cycle", 64'(last_wr), 64'd0);
                checkOutput("finished_cycle", 64'(fin_cyc), 64'd2);
            end else if (stream) begin
                checkOutput("last_wr_cycle", 64'(last_wr), 64'(last_acc + 1));
                checkOutput("finished_cycle", 64'(fin_cyc), 64'(last_acc + 2));
            end else begin
                nb = (int'(cnt) + NP - 1) / NP;
                checkOutput("last_wr_cycle", 64'(last_wr), 64'(nb));
                checkOutput("finished_cycle", 64'(fin_cyc), 64'(nb + 1));
            end
            checkOutput("busy_cycles", 64'(busy_cnt), 64'(fin_cyc - 1));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("idle_busy", 64'(busy), 64'd0);
            checkOutput("idle_finished", 64'(finished), 64'd1);
        end
        checkOutput("beats_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        checkOutput({tag, "_addr"}, 64'(addr), 64'd0);
        checkOutput({tag, "_data"}, 64'(data_out), 64'd0);
        checkOutput({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_finished"}, 64'(finished), 64'd0);
    endtask

    // Only the first two beats are expected; the third is cut off by the reset.
    task automatic resetMidLoad();
        pushPatternBeats(2'd1, 4'd0, 4, 8'h5A);
        @(posedge clk); #1;
        start = 1'b1; mode = 2'd1; base_addr = 4'd0; word_count = 5'd10; fill_value = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_reset_wr_en", 64'(wr_en), 64'h3);
        rst = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        checkOutput("mid_reset_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("post_reset_wr_en", 64'(wr_en), 64'd0);
            checkOutput("post_reset_finished", 64'(finished), 64'd0);
            checkOutput("post_reset_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] ram_init_streamer bench start");
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(2'd1, 4'd0, 5'd5, 8'hA5, 16'h0, 0, 2);
        applyStimulus(2'd2, 4'd14, 5'd4, 8'h10, 16'h0, 0, 0);
        applyStimulus(2'd0, 4'd0, 5'd3, 8'h50, 16'h0, 0, 0);
        applyStimulus(2'd0, 4'd6, 5'd2, 8'h60, 16'b1001, 4, 0);
        applyStimulus(2'd0, 4'd13, 5'd5, 8'h80, 16'b1101011, 7, 0);
        applyStimulus(2'd1, 4'd3, 5'd0, 8'h11, 16'h0, 0, 1);
        applyStimulus(2'd3, 4'd3, 5'd3, 8'h3C, 16'h0, 0, 0);
        applyStimulus(2'd2, 4'd5, 5'd17, 8'hF0, 16'h0, 0, 0);
        resetMidLoad();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
